instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the control unit. Holds the program counter and requests 32-bit instruction words from instruction memory over a req/ack handshake. Latches each returned word and splits it into fields: `op` drives the control unit, while `rd`/`rs`/`rt`/`imm` drive the register file and immediate path. Presents one instruction at a time to decode under a valid/ready handshake, and supports PC redirect.

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 107 ++++++++++
 tb/tb_instr_fetch.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect, and decode-side handshake.
// master = fetch stage, slave = surrounding memory/decode environment.
interface instr_fetch_if #(parameter int PC_W = 16);
  logic            en;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      op;
  logic [3:0]      rd;
  logic [3:0]      rs;
  logic [3:0]      rt;
  logic [15:0]     imm;
  logic [PC_W-1:0] pc_out;
  logic            trap;

  modport master (
    input  en, imem_ack, imem_rdata, redirect, redirect_pc, out_ready,
    output imem_req, imem_addr, out_valid, op, rd, rs, rt, imm, pc_out, trap
  );
  modport slave (
    output en, imem_ack, imem_rdata, redirect, redirect_pc, out_ready,
    input  imem_req, imem_addr, out_valid, op, rd, rs, rt, imm, pc_out, trap
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ack, IR with field split, valid/ready to decode.
// Optional illegal-opcode trap enabled by defining FETCH_ILLEGAL_TRAP_EN.
module instr_fetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic         clk,
  input logic         rst_n,
  instr_fetch_if.master bus
);

`ifdef FETCH_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {IDLE, REQ, FULL, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;
`endif

  state_t          r_state, w_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc_out;
  logic [31:0]     r_ir;
  logic            w_legal;
  logic            w_ack;

  assign w_ack = (r_state == REQ) && bus.imem_ack;

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic r_trap;
  always_comb begin
    w_legal = 1'b0;
    case (bus.imem_rdata[31:28])
      4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end
  assign bus.trap = r_trap;
`else
  assign w_legal  = 1'b1;
  assign bus.trap = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (bus.en) w_nxt = REQ;
      REQ: begin
        if (bus.imem_ack) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
          w_nxt = w_legal ? FULL : TRAP;
`else
          w_nxt = FULL;
`endif
        end
      end
      FULL: if (bus.out_ready) w_nxt = bus.en ? REQ : IDLE;
`ifdef FETCH_ILLEGAL_TRAP_EN
      TRAP: w_nxt = TRAP;
`endif
      default: w_nxt = IDLE;
    endcase
    // redirect wins over ack, handshake and trap
    if (bus.redirect) w_nxt = bus.en ? REQ : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_pc_out <= '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      r_trap   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      if (bus.redirect) begin
        r_pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
        r_ir <= '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
        r_trap <= 1'b0;
`endif
      end else if (w_ack) begin
        // pc_out reports the faulting address on a trap as well
        r_pc_out <= r_pc;
        if (w_legal) begin
          r_ir <= bus.imem_rdata;
          r_pc <= r_pc + PC_W'(PC_STEP);
        end
`ifdef FETCH_ILLEGAL_TRAP_EN
        else r_trap <= 1'b1;
`endif
      end
    end
  end

  assign bus.imem_req  = (r_state == REQ);
  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_state == FULL);
  assign bus.op        = r_ir[31:28];
  assign bus.rd        = r_ir[27:24];
  assign bus.rs        = r_ir[23:20];
  assign bus.rt        = r_ir[19:16];
  assign bus.imm       = r_ir[15:0];
  assign bus.pc_out    = r_pc_out;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked by an
// address model in the memory responder and a scoreboard queue popped on handshakes.
module tb_instr_fetch;
  localparam int PC_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(PC_W)) bus ();
  instr_fetch #(.PC_W(PC_W), .RESET_PC(16'h0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { logic [15:0] addr; logic [31:0] w; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_err = 0, n_pop = 0;
  int lat = 0;
  bit rand_lat = 1'b0;
  logic [15:0] exp_pc = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit legal_op(input logic [3:0] o);
    return (o == 4'h0) || (o == 4'h1) || (o == 4'h3) || (o == 4'h7) || (o == 4'hF);
  endfunction

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] w;
    logic [3:0] ops [5];
    ops = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    if (a == 16'h0000) return 32'h0123_AB1E;
    if (a == 16'h0008) return 32'hA567_1234;
    w = {a ^ 16'h5A5A, a * 16'd37 + 16'h1234};
`ifdef FETCH_ILLEGAL_TRAP_EN
    w[31:28] = ops[a % 5];
`endif
    return w;
  endfunction

  // memory responder: acks after a latency, tracks the architectural PC sequence
  initial begin
    int wcnt, cur_rand, l;
    logic [31:0] w;
    wcnt = 0; cur_rand = 0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        bus.imem_ack = 1'b0; wcnt = 0; exp_pc = 16'h0000;
        continue;
      end
      bus.imem_ack = 1'b0;
      l = rand_lat ? cur_rand : lat;
      if (bus.imem_req) begin
        if (wcnt >= l) begin
          w = mem_word(bus.imem_addr);
          bus.imem_ack = 1'b1; bus.imem_rdata = w; wcnt = 0;
          cur_rand = $urandom_range(0, 2);
          if (!bus.redirect) begin
            chk("ack_addr", {16'h0, bus.imem_addr}, {16'h0, exp_pc});
`ifdef FETCH_ILLEGAL_TRAP_EN
            if (legal_op(w[31:28])) begin
              q.push_back('{bus.imem_addr, w}); exp_pc = exp_pc + 16'd4;
            end
`else
            q.push_back('{bus.imem_addr, w}); exp_pc = exp_pc + 16'd4;
`endif
          end
        end else wcnt++;
      end
      if (bus.redirect) exp_pc = {bus.redirect_pc[15:2], 2'b00};
    end
  end

  // monitor: compare each accepted instruction against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin q.delete(); continue; end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {16'h0, bus.pc_out}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          n_pop++;
          chk("mon_pc",  {16'h0, bus.pc_out}, {16'h0, e.addr});
          chk("mon_op",  {28'h0, bus.op},  {28'h0, e.w[31:28]});
          chk("mon_rd",  {28'h0, bus.rd},  {28'h0, e.w[27:24]});
          chk("mon_rs",  {28'h0, bus.rs},  {28'h0, e.w[23:20]});
          chk("mon_rt",  {28'h0, bus.rt},  {28'h0, e.w[19:16]});
          chk("mon_imm", {16'h0, bus.imm}, {16'h0, e.w[15:0]});
`ifndef FETCH_ILLEGAL_TRAP_EN
          chk("mon_trap0", {31'h0, bus.trap}, 32'h0);
`endif
        end
      end
      if (bus.redirect) q.delete();
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  initial begin
    logic [15:0] imm0, pc0;
    int p0;
    bit got;
    bus.en = 1'b0; bus.out_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (2) tick();
    smp();
    chk("rst_req",   {31'h0, bus.imem_req},  32'h0);
    chk("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_addr",  {16'h0, bus.imem_addr}, 32'h0);
    chk("rst_ir",    {bus.op, bus.rd, bus.rs, bus.rt, bus.imm}, 32'h0);
    chk("rst_pcout", {16'h0, bus.pc_out},    32'h0);
    chk("rst_trap",  {31'h0, bus.trap},      32'h0);
    tick(); rst_n = 1'b1;

    // first fetch, zero-wait memory
    tick(); bus.en = 1'b1;
    smp(); chk("req_not_yet", {31'h0, bus.imem_req}, 32'h0);
    tick(); smp();
    chk("req_after_en", {31'h0, bus.imem_req}, 32'h1);
    chk("addr0", {16'h0, bus.imem_addr}, 32'h0);
    tick(); smp();
    chk("valid1", {31'h0, bus.out_valid}, 32'h1);
    chk("fields1", {bus.op, bus.rd, bus.rs, bus.rt, bus.imm}, 32'h0123_AB1E);
    chk("pcout1", {16'h0, bus.pc_out}, 32'h0);
    imm0 = bus.imm; pc0 = bus.pc_out;
    for (int i = 0; i < 5; i++) begin
      tick(); smp();
      chk("stall_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("stall_noreq", {31'h0, bus.imem_req}, 32'h0);
      chk("stall_imm", {16'h0, bus.imm}, {16'h0, imm0});
      chk("stall_pc", {16'h0, bus.pc_out}, {16'h0, pc0});
    end
    tick(); bus.out_ready = 1'b1;
    tick(); bus.out_ready = 1'b0; lat = 3;
    smp();
    chk("req_after_hs", {31'h0, bus.imem_req}, 32'h1);
    chk("addr4", {16'h0, bus.imem_addr}, 32'h4);

    // slow memory, en dropped mid-request
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); if (i == 0) bus.en = 1'b0;
      smp();
      if (bus.out_valid) begin got = 1'b1; break; end
      chk("wait_req", {31'h0, bus.imem_req}, 32'h1);
      chk("wait_addr", {16'h0, bus.imem_addr}, 32'h4);
    end
    chk("late_delivered", {31'h0, got}, 32'h1);
    chk("late_pcout", {16'h0, bus.pc_out}, 32'h4);
    tick(); bus.out_ready = 1'b1;
    tick(); bus.out_ready = 1'b0; lat = 0;
    smp();
    chk("idle_req", {31'h0, bus.imem_req}, 32'h0);
    chk("idle_valid", {31'h0, bus.out_valid}, 32'h0);

    // redirect coinciding with ack
    tick(); bus.en = 1'b1;
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 16'h0013;
    tick(); bus.redirect = 1'b0;
    smp();
    chk("rd_dropped", {31'h0, bus.out_valid}, 32'h0);
    chk("rd_addr", {16'h0, bus.imem_addr}, 32'h10);
    tick(); smp();
    chk("rd_pcout", {16'h0, bus.pc_out}, 32'h10);
    tick(); bus.out_ready = 1'b1;
    tick(); bus.out_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFC;

    // PC wrap
    tick(); bus.redirect = 1'b0;
    smp(); chk("wrap_addr_fffc", {16'h0, bus.imem_addr}, 32'hFFFC);
    tick(); smp(); chk("wrap_pcout", {16'h0, bus.pc_out}, 32'hFFFC);
    tick(); bus.out_ready = 1'b1;
    tick(); bus.out_ready = 1'b0;
    smp(); chk("wrap_addr0", {16'h0, bus.imem_addr}, 32'h0);
    tick();
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 16'h0008;
    tick(); bus.redirect = 1'b0;
    smp();
    chk("op_a_addr", {16'h0, bus.imem_addr}, 32'h8);
    chk("flush_valid", {31'h0, bus.out_valid}, 32'h0);
    tick(); smp();
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("trap_novalid", {31'h0, bus.out_valid}, 32'h0);
    chk("trap_set", {31'h0, bus.trap}, 32'h1);
    chk("trap_pcout", {16'h0, bus.pc_out}, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick(); smp();
      chk("trap_noreq", {31'h0, bus.imem_req}, 32'h0);
      chk("trap_sticky", {31'h0, bus.trap}, 32'h1);
    end
`else
    chk("opA_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("opA_op", {28'h0, bus.op}, 32'hA);
    chk("opA_pcout", {16'h0, bus.pc_out}, 32'h8);
    chk("opA_trap", {31'h0, bus.trap}, 32'h0);
    tick(); bus.out_ready = 1'b1;
    tick(); bus.out_ready = 1'b0;
`endif
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 16'h0000;
    tick(); bus.redirect = 1'b0;
    smp();
    chk("resume_trap0", {31'h0, bus.trap}, 32'h0);
    chk("resume_req", {31'h0, bus.imem_req}, 32'h1);
    chk("resume_addr", {16'h0, bus.imem_addr}, 32'h0);

    // async reset in the middle of a pending request
    tick(); bus.en = 1'b0; bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0; lat = 3;
    tick(); bus.en = 1'b1;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("arst_addr", {16'h0, bus.imem_addr}, 32'h0);
    chk("arst_valid", {31'h0, bus.out_valid}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // random traffic
    rand_lat = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 2000; i++) begin
      tick();
      bus.en        = ($urandom_range(0, 7) != 0);
      bus.out_ready = $urandom_range(0, 1) != 0;
      bus.redirect  = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = 16'($urandom_range(0, 65535));
    end
    tick(); bus.redirect = 1'b0; bus.en = 1'b0; bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("rand_progress", {31'h0, (n_pop - p0) > 100}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
